// File: rtl/product_digit_scroller.sv
// product_digit_scroller
//
// Turns the 15-bit product magnitude into five registered BCD digits and
// exposes a three-digit window over them. The window is moved one digit at a
// time by the left/right buttons, which are sampled only on divider ticks.
//
// Parameters:
//   DIV_COUNT     sys_clk cycles per tick (>= 2)
//
// Ports:
//   sys_clk       system clock, rising edge
//   rst_n         synchronous active-low reset
//   product       unsigned product magnitude, 0..32767
//   btn_right     debounced right-button level (window towards units)
//   btn_left      debounced left-button level (window towards ten-thousands)
//   tick          one-cycle pulse every DIV_COUNT cycles, display refresh enable
//   bcd           registered BCD of product, [19:16] ten-thousands .. [3:0] units
//   left_digit    most significant digit of the window
//   middle_digit  centre digit of the window
//   right_digit   least significant digit of the window
//   sa/sb/sc      one-hot window position: digits 4..2 / 3..1 / 2..0
//
// Build option:
//   SCROLL_WRAP_EN  when defined the window wraps at both ends instead of
//                   saturating.

module product_digit_scroller #(
    parameter int unsigned DIV_COUNT = 250000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [14:0] product,
    input  logic        btn_right,
    input  logic        btn_left,
    output logic        tick,
    output logic [19:0] bcd,
    output logic [3:0]  left_digit,
    output logic [3:0]  middle_digit,
    output logic [3:0]  right_digit,
    output logic        sa,
    output logic        sb,
    output logic        sc
);

    localparam int unsigned CntW = $clog2(DIV_COUNT);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV_COUNT - 1);

    typedef enum logic [1:0] {
        Pos0 = 2'd0,
        Pos1 = 2'd1,
        Pos2 = 2'd2
    } pos_e;

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD (shift-add-3)
    // ------------------------------------------------------------------
    function automatic logic [19:0] bin_to_bcd(input logic [14:0] bin);
        logic [19:0] acc;
        acc = '0;
        for (int i = 14; i >= 0; i--) begin
            // Any nibble >= 5 would overflow past 9 when doubled; pre-add 3.
            for (int n = 0; n < 5; n++) begin
                if (acc[4*n +: 4] >= 4'd5) begin
                    acc[4*n +: 4] = acc[4*n +: 4] + 4'd3;
                end
            end
            acc = {acc[18:0], bin[i]};
        end
        return acc;
    endfunction

    logic [19:0] bcd_q, bcd_d;

    always_comb begin
        bcd_d = bin_to_bcd(product);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;

    // ------------------------------------------------------------------
    // Button sampling on ticks
    // ------------------------------------------------------------------
    logic btn_left_q, btn_right_q;
    logic press_left, press_right;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            btn_left_q  <= 1'b0;
            btn_right_q <= 1'b0;
        end else if (tick) begin
            btn_left_q  <= btn_left;
            btn_right_q <= btn_right;
        end
    end

    // A press is a 0 -> 1 change between two consecutive tick samples.
    always_comb begin
        press_left  = tick & btn_left  & ~btn_left_q;
        press_right = tick & btn_right & ~btn_right_q;
    end

    // ------------------------------------------------------------------
    // Scroll position
    // ------------------------------------------------------------------
    pos_e pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (press_left && !press_right) begin
            case (pos_q)
                Pos0:    pos_d = Pos1;
                Pos1:    pos_d = Pos2;
`ifdef SCROLL_WRAP_EN
                Pos2:    pos_d = Pos0;
`else
                Pos2:    pos_d = Pos2;
`endif
                default: pos_d = Pos0;
            endcase
        end else if (press_right && !press_left) begin
            case (pos_q)
`ifdef SCROLL_WRAP_EN
                Pos0:    pos_d = Pos2;
`else
                Pos0:    pos_d = Pos0;
`endif
                Pos1:    pos_d = Pos0;
                Pos2:    pos_d = Pos1;
                default: pos_d = Pos0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            pos_q <= Pos0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // ------------------------------------------------------------------
    // Window and indicators
    // ------------------------------------------------------------------
    always_comb begin
        left_digit   = bcd_q[11:8];
        middle_digit = bcd_q[7:4];
        right_digit  = bcd_q[3:0];
        sa           = 1'b0;
        sb           = 1'b0;
        sc           = 1'b1;
        case (pos_q)
            Pos1: begin
                left_digit   = bcd_q[15:12];
                middle_digit = bcd_q[11:8];
                right_digit  = bcd_q[7:4];
                sb           = 1'b1;
                sc           = 1'b0;
            end
            Pos2: begin
                left_digit   = bcd_q[19:16];
                middle_digit = bcd_q[15:12];
                right_digit  = bcd_q[11:8];
                sa           = 1'b1;
                sc           = 1'b0;
            end
            default: begin
                left_digit   = bcd_q[11:8];
                middle_digit = bcd_q[7:4];
                right_digit  = bcd_q[3:0];
            end
        endcase
    end

endmodule

// File: tb/tb_product_digit_scroller.sv
// Self-checking bench for product_digit_scroller with DIV_COUNT = 4.
// A cycle-level reference model is compared against the DUT at every
// falling edge; literal checks pin the model at the scenarios of interest.

module tb_product_digit_scroller;

    localparam int DIV = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [14:0] product;
    logic        btn_right;
    logic        btn_left;
    logic        tick;
    logic [19:0] bcd;
    logic [3:0]  left_digit, middle_digit, right_digit;
    logic        sa, sb, sc;

    int n_tests = 0;
    int n_fail  = 0;

    product_digit_scroller #(.DIV_COUNT(DIV)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .product      (product),
        .btn_right    (btn_right),
        .btn_left     (btn_left),
        .tick         (tick),
        .bcd          (bcd),
        .left_digit   (left_digit),
        .middle_digit (middle_digit),
        .right_digit  (right_digit),
        .sa           (sa),
        .sb           (sb),
        .sc           (sc)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: cycles since reset, decimal digits, window position
    // ------------------------------------------------------------------
    bit          m_valid = 1'b0;
    int          m_cyc;
    int          m_pos;
    bit          m_sl, m_sr;
    logic [19:0] m_bcd;

    function automatic logic [19:0] dec_digits(input int v);
        logic [19:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] m_digit(input int n);
        return 4'((m_bcd >> (4 * n)) & 20'hf);
    endfunction

    always @(posedge sys_clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            m_pos   = 0;
            m_sl    = 1'b0;
            m_sr    = 1'b0;
            m_bcd   = '0;
        end else if (m_valid) begin
            if (m_cyc % DIV == DIV - 1) begin
                bit pl, pr;
                pl = btn_left && !m_sl;
                pr = btn_right && !m_sr;
                if (pl && !pr) begin
`ifdef SCROLL_WRAP_EN
                    m_pos = (m_pos + 1) % 3;
`else
                    m_pos = (m_pos < 2) ? m_pos + 1 : 2;
`endif
                end else if (pr && !pl) begin
`ifdef SCROLL_WRAP_EN
                    m_pos = (m_pos + 2) % 3;
`else
                    m_pos = (m_pos > 0) ? m_pos - 1 : 0;
`endif
                end
                m_sl = btn_left;
                m_sr = btn_right;
            end
            m_bcd = dec_digits(int'(product));
            m_cyc++;
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            check("tick", 32'(tick), 32'(m_cyc % DIV == DIV - 1));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("left_digit", 32'(left_digit), 32'(m_digit(m_pos + 2)));
            check("middle_digit", 32'(middle_digit), 32'(m_digit(m_pos + 1)));
            check("right_digit", 32'(right_digit), 32'(m_digit(m_pos)));
            check("sa", 32'(sa), 32'(m_pos == 2));
            check("sb", 32'(sb), 32'(m_pos == 1));
            check("sc", 32'(sc), 32'(m_pos == 0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Held across two ticks, then released across two ticks: one press.
    task automatic press(input bit left, input bit right);
        btn_left  = left;
        btn_right = right;
        step(2 * DIV);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        step(2 * DIV);
    endtask

    task automatic check_window(input string name, input logic [11:0] digits,
                                input logic [2:0] ind);
        check({name, "_digits"}, 32'({left_digit, middle_digit, right_digit}), 32'(digits));
        check({name, "_ind"}, 32'({sa, sb, sc}), 32'(ind));
    endtask

    int          sweep_in [5];
    logic [19:0] sweep_exp [5];

    initial begin
        rst_n     = 1'b0;
        product   = '0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Reset state, then tick on the fourth cycle after reset.
        check("rst_bcd", 32'(bcd), 32'h0);
        check_window("rst", 12'h000, 3'b001);
        check("rst_tick", 32'(tick), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("tick_phase", 32'(tick), 32'(i == 2));
        end

        product = 15'd32767;
        step(1);
        check("bcd_max", 32'(bcd), 32'h32767);
        check_window("pos0_max", 12'h767, 3'b001);

        press(1'b1, 1'b0);
        check_window("pos1_max", 12'h276, 3'b010);
        press(1'b1, 1'b0);
        check_window("pos2_max", 12'h327, 3'b100);

        // Held across five ticks counts as a single press.
        btn_left = 1'b1;
        step(5 * DIV);
        btn_left = 1'b0;
        step(2 * DIV);
`ifdef SCROLL_WRAP_EN
        check_window("hold_wrap", 12'h767, 3'b001);
`else
        check_window("hold_sat", 12'h327, 3'b100);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check_window("back_pos0", 12'h767, 3'b001);
`endif

        press(1'b0, 1'b1);
`ifdef SCROLL_WRAP_EN
        check_window("right_wrap", 12'h327, 3'b100);
        press(1'b0, 1'b1);
`else
        check_window("right_sat", 12'h767, 3'b001);
        press(1'b1, 1'b0);
`endif
        check_window("pos1_again", 12'h276, 3'b010);

        press(1'b1, 1'b1);
        check_window("both_btn", 12'h276, 3'b010);

        // Pulse that rises and falls between ticks.
        for (int i = 0; i < 2 * DIV && (m_cyc % DIV) != 0; i++) step(1);
        check("pulse_phase", 32'(m_cyc % DIV), 32'h0);
        btn_left = 1'b1;
        step(2);
        btn_left = 1'b0;
        step(2 * DIV);
        check_window("pulse_ignored", 12'h276, 3'b010);

        sweep_in  = '{9, 10, 999, 1000, 12345};
        sweep_exp = '{20'h00009, 20'h00010, 20'h00999, 20'h01000, 20'h12345};
        for (int i = 0; i < 5; i++) begin
            product = 15'(sweep_in[i]);
            step(1);
            check("sweep_bcd", 32'(bcd), 32'(sweep_exp[i]));
        end

        // Random traffic, with one reset mid-count.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 400; i++) begin
                product = 15'($urandom_range(0, 32767));
                if ($urandom_range(0, 5) == 0) btn_left = ~btn_left;
                if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
                step(1);
            end
            if (k == 0) begin
                step($urandom_range(0, DIV - 1));
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
                check("midrst_bcd", 32'(bcd), 32'h0);
                check("midrst_ind", 32'({sa, sb, sc}), 32'h1);
            end
        end

        btn_left  = 1'b0;
        btn_right = 1'b0;
        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
